// File: rtl/bitfield_pipe.sv
// Two-stage ready/valid bit-field unit (cat, pad, bits, head, tail, optional rotate).
// Defining BITFIELD_ROTATE_EN enables the op-5 rotator; otherwise op 5 is reserved.
module bitfield_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  localparam int SH_W = $clog2(IN_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [2:0]        io_in_op,
  input  logic              io_in_signed,
  input  logic [IN_W-1:0]   io_in_a,
  input  logic [IN_W-1:0]   io_in_b,
  input  logic [SH_W-1:0]   io_in_hi,
  input  logic [SH_W-1:0]   io_in_lo,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [OUT_W-1:0]  io_out_bits,
  output logic              io_out_err,
  output logic              io_busy
);

  // One extra bit so field widths up to 2*IN_W are representable.
  localparam int FW_W = SH_W + 1;
  localparam logic [FW_W-1:0] IN_W_F  = FW_W'(IN_W);
  localparam logic [FW_W-1:0] CAT_W_F = FW_W'(2 * IN_W);

  logic              s1_v_q, s1_v_d;
  logic [2:0]        s1_op_q, s1_op_d;
  logic              s1_signed_q, s1_signed_d;
  logic [IN_W-1:0]   s1_a_q, s1_a_d;
  logic [IN_W-1:0]   s1_b_q, s1_b_d;
  logic [SH_W-1:0]   s1_hi_q, s1_hi_d;
  logic [SH_W-1:0]   s1_lo_q, s1_lo_d;
  logic              s2_v_q, s2_v_d;
  logic [OUT_W-1:0]  s2_bits_q, s2_bits_d;
  logic              s2_err_q, s2_err_d;

  logic              accept_s;
  logic              move_s;
  logic [OUT_W-1:0]  a_ext_s;
  logic [OUT_W-1:0]  val_s;
  logic [OUT_W-1:0]  mask_s;
  logic [OUT_W-1:0]  top_s;
  logic [OUT_W-1:0]  res_s;
  logic [FW_W-1:0]   fw_s;
  logic [FW_W-1:0]   hi_f_s;
  logic [FW_W-1:0]   lo_f_s;
  logic              sext_s;
  logic              sign_s;
  logic              err_s;

`ifdef BITFIELD_ROTATE_EN
  logic [SH_W-1:0]   rot_amt_s;
  logic [2*IN_W-1:0] rot_dbl_s;
  logic [IN_W-1:0]   rot_s;

  always_comb begin
    rot_amt_s = s1_lo_q % SH_W'(IN_W);
    rot_dbl_s = {s1_a_q, s1_a_q} << rot_amt_s;
    rot_s     = rot_dbl_s[2*IN_W-1:IN_W];
  end
`endif

  // Field extraction: val_s is right-justified raw data, fw_s its width.
  always_comb begin
    a_ext_s = OUT_W'(s1_a_q);
    hi_f_s  = {1'b0, s1_hi_q};
    lo_f_s  = {1'b0, s1_lo_q};
    val_s   = '0;
    fw_s    = '0;
    sext_s  = s1_signed_q;
    err_s   = 1'b0;
    case (s1_op_q)
      3'd0: begin
        val_s = OUT_W'({s1_a_q, s1_b_q});
        fw_s  = CAT_W_F;
      end
      3'd1: begin
        val_s = a_ext_s;
        fw_s  = IN_W_F;
      end
      3'd2: begin
        if ((hi_f_s < lo_f_s) || (hi_f_s >= IN_W_F)) begin
          err_s = 1'b1;
        end else begin
          val_s = a_ext_s >> s1_lo_q;
          fw_s  = hi_f_s - lo_f_s + FW_W'(1);
        end
      end
      3'd3: begin
        if ((lo_f_s == '0) || (lo_f_s > IN_W_F)) begin
          err_s = 1'b1;
        end else begin
          val_s = a_ext_s >> (IN_W_F - lo_f_s);
          fw_s  = lo_f_s;
        end
      end
      3'd4: begin
        if (lo_f_s >= IN_W_F) begin
          err_s = 1'b1;
        end else begin
          val_s = a_ext_s;
          fw_s  = IN_W_F - lo_f_s;
        end
      end
`ifdef BITFIELD_ROTATE_EN
      3'd5: begin
        val_s  = OUT_W'(rot_s);
        fw_s   = IN_W_F;
        sext_s = 1'b0;
      end
`endif
      default: begin
        err_s = 1'b1;
      end
    endcase

    // Sign bit is the top set bit of the width mask.
    mask_s = ~({OUT_W{1'b1}} << fw_s);
    top_s  = mask_s & ~(mask_s >> 1);
    sign_s = |(val_s & top_s);
    if (err_s) begin
      res_s = '0;
    end else if (sext_s && sign_s) begin
      res_s = (val_s & mask_s) | ~mask_s;
    end else begin
      res_s = val_s & mask_s;
    end
  end

  // Handshake and next-state for both stages.
  always_comb begin
    io_in_ready = !s1_v_q || !s2_v_q || io_out_ready;
    accept_s    = io_in_valid && io_in_ready;
    move_s      = s1_v_q && (!s2_v_q || io_out_ready);

    s1_op_d     = s1_op_q;
    s1_signed_d = s1_signed_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_hi_d     = s1_hi_q;
    s1_lo_d     = s1_lo_q;
    if (accept_s) begin
      s1_v_d      = 1'b1;
      s1_op_d     = io_in_op;
      s1_signed_d = io_in_signed;
      s1_a_d      = io_in_a;
      s1_b_d      = io_in_b;
      s1_hi_d     = io_in_hi;
      s1_lo_d     = io_in_lo;
    end else if (move_s) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    s2_bits_d = s2_bits_q;
    s2_err_d  = s2_err_q;
    if (move_s) begin
      s2_v_d    = 1'b1;
      s2_bits_d = res_s;
      s2_err_d  = err_s;
    end else if (io_out_ready) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_op_q     <= 3'd0;
      s1_signed_q <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_hi_q     <= '0;
      s1_lo_q     <= '0;
      s2_v_q      <= 1'b0;
      s2_bits_q   <= '0;
      s2_err_q    <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_op_q     <= s1_op_d;
      s1_signed_q <= s1_signed_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_hi_q     <= s1_hi_d;
      s1_lo_q     <= s1_lo_d;
      s2_v_q      <= s2_v_d;
      s2_bits_q   <= s2_bits_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign io_out_valid = s2_v_q;
  assign io_out_bits  = s2_bits_q;
  assign io_out_err   = s2_err_q;
  assign io_busy      = s1_v_q || s2_v_q;

endmodule
